div_share_ctrl: RTL and testbench

- Sequencer/arbiter sharing one 32-bit multi-cycle divider (Run/Rdy style: run pulse starts, rdy flags done) between two requesters.
- Arbitrates requests, latches operands, clears and launches the divider, waits for completion with a watchdog, and returns quotient/remainder to the granted requester.
- Sits between the two client datapaths and the single divider instance.

---
 rtl/div_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// ============================================================================
// Module      : div_share_ctrl
// Description : Round-robin sequencer sharing one Run/Rdy divider between two
//               requesters. Optional macro DIV_ZERO_BYPASS_EN answers x/0
//               locally without launching the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_dvnd,
  input  logic [WIDTH-1:0] req0_dvsr,
  input  logic [WIDTH-1:0] req1_dvnd,
  input  logic [WIDTH-1:0] req1_dvsr,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_err,
  output logic [WIDTH-1:0] div_dvnd,
  output logic [WIDTH-1:0] div_dvsr,
  output logic             div_run,
  output logic             div_rst,
  input  logic             div_rdy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_last_grant;
  logic [WIDTH-1:0]   r_op_dvnd;
  logic [WIDTH-1:0]   r_op_dvsr;
  logic [WIDTH-1:0]   r_rsp_q;
  logic [WIDTH-1:0]   r_rsp_r;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_any;
  logic               w_grant;
  logic               w_bypass;
  logic               w_timeout;
  logic [WIDTH-1:0]   w_sel_dvnd;
  logic [WIDTH-1:0]   w_sel_dvsr;

  // On a tie the requester that did not win last time is served.
  assign w_any      = |req_valid;
  assign w_grant    = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_sel_dvnd = w_grant ? req1_dvnd : req0_dvnd;
  assign w_sel_dvsr = w_grant ? req1_dvsr : req0_dvsr;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = (w_sel_dvsr == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_any && Rst) begin
          req_ready   = w_grant ? 2'b10 : 2'b01;
          w_state_nxt = w_bypass ? S_DONE : S_CLR;
        end
      end
      S_CLR:  w_state_nxt = S_RUN;
      S_RUN:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (div_rdy || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready[r_owner]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op_dvnd    <= '0;
      r_op_dvsr    <= '0;
      r_rsp_q      <= '0;
      r_rsp_r      <= '0;
      r_rsp_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_op_dvnd    <= w_sel_dvnd;
            r_op_dvsr    <= w_sel_dvsr;
            if (w_bypass) begin
              r_rsp_q   <= '1;
              r_rsp_r   <= w_sel_dvnd;
              r_rsp_err <= 1'b0;
            end
          end
        end
        S_RUN: r_cnt <= '0;
        S_WAIT: begin
          // A result arriving on the last watchdog cycle is still taken.
          if (div_rdy) begin
            r_rsp_q   <= div_q;
            r_rsp_r   <= div_r;
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_q   <= '0;
            r_rsp_r   <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_q     = r_rsp_q;
  assign rsp_r     = r_rsp_r;
  assign rsp_err   = r_rsp_err;
  assign div_dvnd  = r_op_dvnd;
  assign div_dvsr  = r_op_dvsr;
  assign div_run   = (r_state == S_RUN);
  assign div_rst   = ~Rst | (r_state == S_CLR);

endmodule

`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
// ============================================================================
// Module      : tb_div_share_ctrl
// Description : Scoreboard bench for div_share_ctrl with a behavioural divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_share_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             Rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_dvnd, req0_dvsr, req1_dvnd, req1_dvsr;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_q, rsp_r;
  logic             rsp_err;
  logic [WIDTH-1:0] div_dvnd, div_dvsr;
  logic             div_run, div_rst;
  logic             div_rdy = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic [WIDTH-1:0] div_r = '0;

  div_share_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_dvnd(req0_dvnd), .req0_dvsr(req0_dvsr),
    .req1_dvnd(req1_dvnd), .req1_dvsr(req1_dvsr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
    .div_run(div_run), .div_rst(div_rst),
    .div_rdy(div_rdy), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Divider stub: rdy rises lat cycles after the run pulse, so it is first
  // visible in WAIT cycle lat+1; hang suppresses rdy entirely.
  int lat  = 33;
  bit hang = 1'b0;
  int left = 0;
  bit busy = 1'b0;
  always @(posedge clk) begin
    if (div_rst) begin
      div_rdy <= 1'b0;
      busy    <= 1'b0;
    end else if (div_run) begin
      busy    <= !hang;
      left    <= lat - 1;
      div_rdy <= 1'b0;
    end else if (busy) begin
      if (left == 0) begin
        div_rdy <= 1'b1;
        busy    <= 1'b0;
        div_q   <= (div_dvsr == 0) ? '1 : div_dvnd / div_dvsr;
        div_r   <= (div_dvsr == 0) ? div_dvnd : div_dvnd % div_dvsr;
      end else begin
        left <= left - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard
  typedef struct {
    bit          own;
    logic [31:0] q;
    logic [31:0] r;
    bit          err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m_e;
  bit          m_last = 1'b1;
  bit          m_g;
  bit          m_byp;
  bit          outstanding = 1'b0;
  int          exp_run = -1;
  logic [31:0] m_dd, m_ds;

  always @(negedge clk) begin
    if (Rst === 1'b1) begin
      if (req_ready != 2'b00) begin
        m_g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        chk("grant", 32'(req_ready), m_g ? 32'd2 : 32'd1);
        chk("single_outstanding", 32'(outstanding), 32'd0);
        m_dd  = m_g ? req1_dvnd : req0_dvnd;
        m_ds  = m_g ? req1_dvsr : req0_dvsr;
        m_byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        m_byp = (m_ds == 0);
`endif
        m_e.own = m_g;
        if (!m_byp && (hang || (lat + 1 > TIMEOUT))) begin
          m_e.err = 1'b1; m_e.q = 0; m_e.r = 0;
        end else if (m_ds == 0) begin
          m_e.err = 1'b0; m_e.q = 32'hFFFF_FFFF; m_e.r = m_dd;
        end else begin
          m_e.err = 1'b0; m_e.q = m_dd / m_ds; m_e.r = m_dd % m_ds;
        end
        sbq.push_back(m_e);
        m_last      = m_g;
        outstanding = 1'b1;
        exp_run     = m_byp ? -1 : cyc + 2;
      end
      if (div_run) begin
        chk("run_latency", 32'(cyc), 32'(exp_run));
        exp_run = -1;
      end
      if (rsp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rsp: got rsp_valid %b expected none", rsp_valid);
        end else begin
          m_e = sbq[0];
          chk("rsp_owner", 32'(rsp_valid), m_e.own ? 32'd2 : 32'd1);
          chk("rsp_q", rsp_q, m_e.q);
          chk("rsp_r", rsp_r, m_e.r);
          chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
          if (rsp_ready[m_e.own]) begin
            void'(sbq.pop_front());
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  bit hold_rsp = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_ready = hold_rsp ? 2'b00 : 2'($urandom_range(0, 3));
  end

  task automatic send(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    logic [1:0] acc;
    @(posedge clk); #1;
    req0_dvnd = a0; req0_dvsr = b0; req1_dvnd = a1; req1_dvsr = b1;
    req_valid = mask;
    for (int k = 0; k < 2000 && req_valid != 2'b00; k++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    if (req_valid != 2'b00) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got pending %b expected 00", req_valid);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = (sbq.size() == 0) && !outstanding;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete(); outstanding = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_q", rsp_q, 32'd0);
    chk("rst_rsp_r", rsp_r, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_div_dvnd", div_dvnd, 32'd0);
    chk("rst_div_dvsr", div_dvsr, 32'd0);
    chk("rst_div_run", 32'(div_run), 32'd0);
    chk("rst_div_rst", 32'(div_rst), 32'd1);
  endtask

  initial begin
    Rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_dvnd = 0; req0_dvsr = 0; req1_dvnd = 0; req1_dvsr = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs();
    @(posedge clk); #1; Rst = 1'b1;

    // Contention first: the first tie after reset must go to requester 0
    lat = 33;
    send(2'b11, 50, 5, 9, 4);   wait_idle();
    send(2'b11, 60, 7, 20, 6);  wait_idle();
    send(2'b01, 100, 7, 0, 0);  wait_idle();
    send(2'b10, 0, 0, 99, 10);  wait_idle();

    // Backpressure: no rsp_ready for 14 cycles with req1 pending
    fork
      send(2'b11, 1000, 9, 77, 8);
      begin
        hold_rsp = 1'b1;
        repeat (14) @(posedge clk);
        #2 hold_rsp = 1'b0;
      end
    join
    wait_idle();

    // Watchdog boundary
    hang = 1'b1; send(2'b01, 77, 3, 0, 0);   wait_idle(); hang = 1'b0;
    lat = 64;    send(2'b10, 0, 0, 500, 3);  wait_idle();
    lat = 63;    send(2'b01, 501, 4, 0, 0);  wait_idle();
    lat = 33;

    // Divide by zero
    send(2'b01, 1234, 0, 0, 0); wait_idle();

    // Reset in the middle of WAIT
    lat = 50;
    send(2'b01, 5000, 3, 0, 0);
    repeat (20) @(posedge clk);
    #1 Rst = 1'b0;
    #1 chk_reset_outputs();
    sbq.delete(); outstanding = 1'b0; m_last = 1'b1; exp_run = -1;
    repeat (3) @(posedge clk);
    #1 Rst = 1'b1;
    lat = 33;
    send(2'b11, 444, 11, 333, 12); wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a0, b0, a1, b1;
      lat  = $urandom_range(1, 40);
      hang = ($urandom_range(0, 9) == 0);
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 5) == 0) ? 0 : ($urandom >> $urandom_range(0, 31));
      b1 = ($urandom_range(0, 5) == 0) ? 0 : ($urandom >> $urandom_range(0, 31));
      send(2'($urandom_range(1, 3)), a0, b0, a1, b1);
      wait_idle();
    end
    hang = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
